// File: rtl/mem_fetch_pkg.sv
// Shared types and constants for the byte-serial memory word fetcher.
//   fetch_state_t : fetcher FSM states
//   BYTE_W/ADDR_W/WORD_W/MAX_BYTES : datapath geometry
//   LANE_W : width of a byte-lane index within the assembled word
package mem_fetch_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MAX_BYTES = 4;
  localparam int unsigned LANE_W    = $clog2(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } fetch_state_t;

  // Byte lane for the count-th byte of a (len+1)-byte fetch.
  function automatic logic [LANE_W-1:0] byte_lane(input logic              big_endian,
                                                  input logic [LANE_W-1:0] len,
                                                  input logic [LANE_W-1:0] count);
    logic [LANE_W-1:0] diff;
    diff = len - count;
    return big_endian ? diff : count;
  endfunction

endpackage

// File: rtl/mem_fetch_assembler.sv
// Holds the assembled data word and merges incoming bytes into it.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears the word
//   clr_i  : synchronous clear (new fetch accepted); wins over we_i
//   we_i   : write byte_i into lane lane_i
//   lane_i : destination byte lane
//   byte_i : byte from memory
//   data_o : registered assembled word
module mem_fetch_assembler
  import mem_fetch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] data_o
);

  logic [WORD_W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (we_i) begin
      data_d[lane_i*BYTE_W +: BYTE_W] = byte_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/mem_word_fetcher.sv
// Reads 1-4 consecutive bytes from byte-wide memory and assembles them into a word.
//   Clock/Reset       : clock, asynchronous active-high reset
//   Start/Addr/Len    : fetch request (sampled in IDLE), start address, byte count - 1
//   MemData/MemReady  : memory read data and ready (accept + data valid this cycle)
//   MemAddr/MemRead   : registered memory address and read request
//   Data              : assembled word, upper unused bytes zero
//   Busy/Done         : fetch in progress / one-cycle completion pulse
module mem_word_fetcher
  import mem_fetch_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [LANE_W-1:0] Len,
  input  logic [BYTE_W-1:0] MemData,
  input  logic              MemReady,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic [WORD_W-1:0] Data,
  output logic              Busy,
  output logic              Done
);

  fetch_state_t      state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic [LANE_W-1:0] cnt_d, cnt_q;
  logic [LANE_W-1:0] len_d, len_q;
  logic              mem_read_d, mem_read_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              clr;
  logic              we;
  logic [LANE_W-1:0] lane;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      mem_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      mem_read_q <= mem_read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    clr     = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          ptr_d   = Addr;
          len_d   = Len;
          cnt_d   = '0;
          clr     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (MemReady) begin
          we = 1'b1;
          if (cnt_q == len_q) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + 16'd1;
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered: their next values are decoded from the next state
  always_comb begin
    mem_read_d = (state_d == REQ);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  assign lane = byte_lane(BIG_ENDIAN, len_q, cnt_q);

  mem_fetch_assembler u_assembler (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .clr_i  (clr),
    .we_i   (we),
    .lane_i (lane),
    .byte_i (MemData),
    .data_o (Data)
  );

  assign MemAddr = ptr_q;
  assign MemRead = mem_read_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_mem_word_fetcher.sv
module tb_mem_word_fetcher;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] addr;
  logic [1:0]  len;
  logic        ready;

  logic [15:0] le_mem_addr, be_mem_addr;
  logic [7:0]  le_mem_data, be_mem_data;
  logic        le_mem_read, be_mem_read;
  logic [31:0] le_data, be_data;
  logic        le_busy, be_busy;
  logic        le_done, be_done;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  len;
    int          stall_byte;
    int          stall_n;
    logic [31:0] exp_le;
    logic [31:0] exp_be;
  } vec_t;

  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h11;
      16'h0011: return 8'h22;
      16'h0012: return 8'h33;
      16'h0013: return 8'h44;
      16'hFFFE: return 8'hA1;
      16'hFFFF: return 8'hB2;
      16'h0000: return 8'hC3;
      16'h0001: return 8'hD4;
      16'h0100: return 8'hAA;
      16'h0101: return 8'hBB;
      16'h0200: return 8'hAB;
      16'h0201: return 8'hCD;
      16'h0300: return 8'h5A;
      default:  return a[7:0] ^ 8'h5C;
    endcase
  endfunction

  always_comb le_mem_data = mem_byte(le_mem_addr);
  always_comb be_mem_data = mem_byte(be_mem_addr);

  mem_word_fetcher #(.BIG_ENDIAN(1'b0)) dut_le (
    .Clock    (clk),
    .Reset    (rst),
    .Start    (start),
    .Addr     (addr),
    .Len      (len),
    .MemData  (le_mem_data),
    .MemReady (ready),
    .MemAddr  (le_mem_addr),
    .MemRead  (le_mem_read),
    .Data     (le_data),
    .Busy     (le_busy),
    .Done     (le_done)
  );

  mem_word_fetcher #(.BIG_ENDIAN(1'b1)) dut_be (
    .Clock    (clk),
    .Reset    (rst),
    .Start    (start),
    .Addr     (addr),
    .Len      (len),
    .MemData  (be_mem_data),
    .MemReady (ready),
    .MemAddr  (be_mem_addr),
    .MemRead  (be_mem_read),
    .Data     (be_data),
    .Busy     (be_busy),
    .Done     (be_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " memaddr"}, {16'h0, le_mem_addr}, 32'h0);
    check({tag, " memread"}, {31'h0, le_mem_read}, 32'h0);
    check({tag, " data"}, le_data, 32'h0);
    check({tag, " busy"}, {31'h0, le_busy}, 32'h0);
    check({tag, " done"}, {31'h0, le_done}, 32'h0);
    check({tag, " be data"}, be_data, 32'h0);
  endtask

  // One fetch driven from negedges; MemAddr is checked every REQ cycle and the stall
  // (MemReady low for stall_n cycles on byte stall_byte) must hold it steady.
  task automatic do_fetch(input vec_t v);
    int idx;
    int stall_left;
    int edges;
    logic [15:0] exp_addr;
    @(negedge clk);
    addr  = v.addr;
    len   = v.len;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr  = 16'h0BAD;
    len   = ~v.len;
    idx        = 0;
    stall_left = v.stall_n;
    edges      = 0;
    while (!le_done && edges < 40) begin
      if (le_mem_read) begin
        exp_addr = v.addr + 16'(idx);
        check("memaddr", {16'h0, le_mem_addr}, {16'h0, exp_addr});
        check("be memaddr", {16'h0, be_mem_addr}, {16'h0, exp_addr});
        check("busy in req", {31'h0, le_busy}, 32'h1);
        if (idx == v.stall_byte && stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
        end else begin
          ready = 1'b1;
          idx++;
        end
      end else begin
        ready = 1'b1;
      end
      @(negedge clk);
      edges++;
    end
    check("done seen", {31'h0, le_done}, 32'h1);
    check("done edge", 32'(edges), 32'(v.len) + 32'd1 + 32'(v.stall_n));
    check("be done", {31'h0, be_done}, 32'h1);
    check("busy in done", {31'h0, le_busy}, 32'h1);
    check("memread in done", {31'h0, le_mem_read}, 32'h0);
    check("data le", le_data, v.exp_le);
    check("data be", be_data, v.exp_be);
    @(negedge clk);
    check("done one cycle", {31'h0, le_done}, 32'h0);
    check("idle busy", {31'h0, le_busy}, 32'h0);
    check("data held", le_data, v.exp_le);
  endtask

  initial begin
    int dones;

    vecs[0] = '{16'h0010, 2'd3, -1, 0, 32'h44332211, 32'h11223344};
    vecs[1] = '{16'hFFFE, 2'd3, -1, 0, 32'hD4C3B2A1, 32'hA1B2C3D4};
    vecs[2] = '{16'h0100, 2'd1,  1, 3, 32'h0000BBAA, 32'h0000AABB};
    vecs[3] = '{16'h0200, 2'd1, -1, 0, 32'h0000CDAB, 32'h0000ABCD};
    vecs[4] = '{16'h0300, 2'd0, -1, 0, 32'h0000005A, 32'h0000005A};
    vecs[5] = '{16'h0010, 2'd2,  0, 2, 32'h00332211, 32'h00112233};

    rst   = 1'b1;
    start = 1'b0;
    addr  = 16'h0;
    len   = 2'd0;
    ready = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_fetch(vecs[i]);
    end

    // Reset while idle with a nonzero Data and pointer
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("idle reset");
    @(negedge clk);
    rst = 1'b0;

    // Start held high through REQ and DONE must not launch a second fetch
    @(negedge clk);
    addr  = 16'h0100;
    len   = 2'd1;
    start = 1'b1;
    @(negedge clk);
    addr  = 16'h0300;
    len   = 2'd0;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (le_done) dones++;
    end
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (le_done) dones++;
    end
    check("ignored start dones", 32'(dones), 32'd1);
    check("ignored start data", le_data, 32'h0000BBAA);
    check("ignored start busy", {31'h0, le_busy}, 32'h0);
    check("ignored start addr", {16'h0, le_mem_addr}, 32'h0000_0101);

    // Reset while the second byte is pending aborts the fetch
    @(negedge clk);
    addr  = 16'h0010;
    len   = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort pre data", le_data, 32'h00000011);
    check("abort pre addr", {16'h0, le_mem_addr}, 32'h0000_0011);
    rst = 1'b1;
    #1;
    check_all_zero("req reset");
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (le_done) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    check("abort data", le_data, 32'h0);
    do_fetch(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
